// File: rtl/fifo_in_stage.sv
// First-word fall-through FIFO in front of the WIDTH-bit register stage.
// Reports occupancy and full/empty status, and latches push attempts made while full.
module fifo_in_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_d,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_q,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             overflow_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [AW:0]      count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign full_s  = (count_s == (AW+1)'(DEPTH));
    assign empty_s = (count_s == {(AW+1){1'b0}});

    // Handshake qualification from registered status only.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!i_flush) begin
            push_s = i_valid & ~full_s;
            pop_s  = i_ready & ~empty_s;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Pointer and sticky overflow state; flush overrides any push or pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else if (i_flush) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (i_valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= i_d;
        end
    end

    // Head word is forced to zero while nothing is held.
    always_comb begin
        o_q = {WIDTH{1'b0}};
        if (!empty_s) begin
            o_q = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            o_q = {WIDTH{1'b0}};
        end
    end

    assign o_count    = count_s;
    assign o_full     = full_s;
    assign o_empty    = empty_s;
    assign o_ready    = ~full_s;
    assign o_valid    = ~empty_s;
    assign o_overflow = overflow_r;
endmodule

// File: tb/tb_fifo_in_stage.sv
// Randomised, scoreboard-checked bench for fifo_in_stage against a queue model.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_fifo_in_stage;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_d;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_q;
    logic [2:0]       o_count;
    logic             o_full;
    logic             o_empty;
    logic             o_overflow;

    logic [WIDTH-1:0] exp_q[$];
    bit               ovf_exp;
    int               n_checks;
    int               n_errors;

    fifo_in_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_d(i_d),
        .o_valid(o_valid), .i_ready(i_ready), .o_q(o_q),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = exp_q.size();
        check("count", int'(o_count), sz);
        check("full", int'(o_full), int'(sz == DEPTH));
        check("empty", int'(o_empty), int'(sz == 0));
        check("ready", int'(o_ready), int'(sz != DEPTH));
        check("valid", int'(o_valid), int'(sz != 0));
        check("overflow", int'(o_overflow), int'(ovf_exp));
        check("head", int'(o_q), (sz != 0) ? int'(exp_q[0]) : 0);
    endtask

    // One clock of stimulus; the model is advanced right after the edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic r, input logic f);
        bit will_push;
        bit was_full;
        i_valid = v; i_d = d; i_ready = r; i_flush = f;
        check_status();
        was_full  = (exp_q.size() == DEPTH);
        will_push = v && !f && !was_full;
        @(posedge clk);
        #1;
        if (f) begin
            exp_q.delete();
            ovf_exp = 1'b0;
        end else begin
            if (will_push) exp_q.push_back(d);
            if (v && was_full) ovf_exp = 1'b1;
        end
    endtask

    // Scoreboard monitor: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !i_flush && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("pop_data", int'(o_q), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int idx;
        bit tog;
        n_checks = 0; n_errors = 0; ovf_exp = 1'b0;
        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_d = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rst_n = 1'b1;

        // Fill to full, then one push too many.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        // Pop one to reach count 3 with overflow still set, then flush carrying a word.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Drain with wrap-around while the consumer toggles.
        idx = 0; tog = 1'b1;
        while (idx < 10) begin
            if (exp_q.size() < DEPTH) begin
                cycle(1'b1, 8'hA0 + idx[7:0], tog, 1'b0);
                idx++;
            end else begin
                cycle(1'b0, 8'h00, tog, 1'b0);
            end
            tog = ~tog;
        end
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Concurrent push and pop at count 2.
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic including occasional flushes and overflow attempts.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset between edges while holding three words.
        cycle(1'b1, 8'h81, 1'b0, 1'b0);
        cycle(1'b1, 8'h82, 1'b0, 1'b0);
        cycle(1'b1, 8'h83, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_q", int'(o_q), 0);
        exp_q.delete();
        ovf_exp = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst_head", int'(o_q), 32'h77);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
